cpu_step_controller: RTL and testbench

Sequences execution of the lab CPU under the on-board debugger. It turns raw push-button inputs into clean single-step, multi-step and free-run commands and produces the per-cycle clock enable that advances the CPU. It halts on a programmable PC breakpoint and keeps an executed-cycle counter for the state display. It sits between the board buttons and the CPU core inside the debugger top level.

---
 rtl/cpu_step_controller.sv | 146 ++++++++++++++
 tb/tb_cpu_step_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller.sv
// Debugger step/run sequencer for the lab CPU.
// Debounces buttons, gates the CPU clock enable, stops on a PC breakpoint.
module cpu_step_controller #(
  parameter int p_address_width     = 10,
  parameter int p_debounce_cycles   = 4,
  parameter int p_cycle_count_width = 16
) (
  input  logic                           i_w_clk,
  input  logic                           i_w_reset,
  input  logic                           i_w_step,
  input  logic                           i_w_run,
  input  logic [3:0]                     i_w_steps,
  input  logic                           i_w_bp_en,
  input  logic [p_address_width-1:0]     i_w_bp_addr,
  input  logic [p_address_width-1:0]     i_w_pc,
  output logic                           o_w_cpu_clk_en,
  output logic                           o_w_halted,
  output logic                           o_w_bp_hit,
  output logic [p_cycle_count_width-1:0] o_w_cycle_count
);

  localparam int dbw = $clog2(p_debounce_cycles + 1);
  localparam logic [dbw-1:0] db_last = dbw'(p_debounce_cycles - 1);

  typedef enum logic [1:0] {
    st_halt,
    st_step,
    st_run,
    st_break
  } state_t;

  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     deb;
  logic [1:0]     press;
  logic [dbw-1:0] cnt [2];

  assign raw = {i_w_run, i_w_step};

  // bit 0 = step, bit 1 = run
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int b = 0; b < 2; b++) cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        press[b] <= 1'b0;
        if (sync2[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == db_last) begin
          cnt[b]   <= '0;
          deb[b]   <= sync2[b];
          press[b] <= sync2[b];
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  state_t     state;
  state_t     state_nx;
  logic [3:0] remaining;
  logic [3:0] remaining_nx;
  logic [3:0] step_load;
  logic       skip;
  logic       bp_match;
  logic       step_press;
  logic       run_press;
  logic       cpu_clk_en;

  assign step_press = press[0];
  assign run_press  = press[1];
  assign step_load  = (i_w_steps == 4'd0) ? 4'd1 : i_w_steps;
  assign bp_match   = i_w_bp_en && (i_w_pc == i_w_bp_addr) && !skip;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    cpu_clk_en   = 1'b0;
    unique case (state)
      st_halt: begin
        if (run_press) begin
          state_nx = st_run;
        end else if (step_press) begin
          state_nx     = st_step;
          remaining_nx = step_load;
        end
      end
      st_step: begin
        cpu_clk_en   = 1'b1;
        remaining_nx = remaining - 4'd1;
        if (remaining <= 4'd1) state_nx = st_halt;
      end
      st_run: begin
        if (bp_match) begin
          state_nx = st_break;
        end else begin
          cpu_clk_en = 1'b1;
          if (run_press) state_nx = st_halt;
        end
      end
      st_break: begin
        if (run_press) begin
          state_nx = st_run;
        end else if (step_press) begin
          state_nx     = st_step;
          remaining_nx = step_load;
        end
      end
      default: state_nx = st_halt;
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state           <= st_halt;
      remaining       <= '0;
      skip            <= 1'b0;
      o_w_halted      <= 1'b1;
      o_w_bp_hit      <= 1'b0;
      o_w_cycle_count <= '0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      // first RUN cycle ignores the breakpoint so resume can leave it
      skip       <= (state_nx == st_run) && (state != st_run);
      o_w_halted <= (state_nx == st_halt) || (state_nx == st_break);
      if (state == st_run && bp_match) begin
        o_w_bp_hit <= 1'b1;
      end else if (state == st_break && state_nx != st_break) begin
        o_w_bp_hit <= 1'b0;
      end
      if (cpu_clk_en) o_w_cycle_count <= o_w_cycle_count + 1'b1;
    end
  end

  assign o_w_cpu_clk_en = cpu_clk_en;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller.
// Expected values are queued with each stimulus and popped on check.
module tb_cpu_step_controller;

  localparam int aw = 10;
  localparam int cw = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step = 1'b0;
  logic          run = 1'b0;
  logic [3:0]    steps = 4'd0;
  logic          bp_en = 1'b0;
  logic [aw-1:0] bp_addr = '0;
  logic [aw-1:0] pc;
  logic          clk_en;
  logic          halted;
  logic          bp_hit;
  logic [cw-1:0] count;

  int total = 0;
  int bad = 0;
  int en_seen = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // CPU PC model: advances on each enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (clk_en) pc <= pc + 1'b1;
  end

  cpu_step_controller #(
    .p_address_width(aw),
    .p_debounce_cycles(4),
    .p_cycle_count_width(cw)
  ) dut (
    .i_w_clk(clk),
    .i_w_reset(rst_n),
    .i_w_step(step),
    .i_w_run(run),
    .i_w_steps(steps),
    .i_w_bp_en(bp_en),
    .i_w_bp_addr(bp_addr),
    .i_w_pc(pc),
    .o_w_cpu_clk_en(clk_en),
    .o_w_halted(halted),
    .o_w_bp_hit(bp_hit),
    .o_w_cycle_count(count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pop();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rst_n && clk_en === 1'b1) en_seen++;
  endtask

  // cycle 0 is the cycle in which the raw buttons rise
  task automatic press_window(input bit s, input bit r, input int ncyc,
                              input int late_steps,
                              output int first, output int last,
                              output int n, output int hnext);
    bit prev;
    first = -1;
    last  = -1;
    n     = 0;
    hnext = -1;
    prev  = 1'b0;
    step  = s;
    run   = r;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (clk_en) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end else if (prev) begin
        hnext = int'(halted);
      end
      prev = clk_en;
      if (c == 7 && late_steps >= 0) steps = late_steps[3:0];
      if (c == 9) begin
        step = 1'b0;
        run  = 1'b0;
      end
    end
  endtask

  int first, last, n, hnext, ne, len, bc, base;

  initial begin
    rst_n = 1'b0;
    repeat (5) tick();
    check("rst_halted", halted, 1);
    check("rst_clk_en", clk_en, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    en_seen = 0;
    repeat (3) tick();

    steps = 4'd3;
    exp_q.push_back(7); exp_q.push_back(9); exp_q.push_back(3);
    exp_q.push_back(1); exp_q.push_back(3);
    press_window(1, 0, 16, -1, first, last, n, hnext);
    check("step3_first", first, pop());
    check("step3_last", last, pop());
    check("step3_n", n, pop());
    check("step3_halt_next", hnext, pop());
    check("step3_count", count, pop());

    steps = 4'd0;
    exp_q.push_back(7); exp_q.push_back(7); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(4);
    press_window(1, 0, 16, -1, first, last, n, hnext);
    check("step0_first", first, pop());
    check("step0_last", last, pop());
    check("step0_n", n, pop());
    check("step0_halt_next", hnext, pop());
    check("step0_count", count, pop());

    steps = 4'd3;
    exp_q.push_back(3); exp_q.push_back(7);
    press_window(1, 0, 24, 15, first, last, n, hnext);
    check("late_steps_n", n, pop());
    check("late_steps_count", count, pop());

    exp_q.push_back(0); exp_q.push_back(7);
    ne = 0;
    bc = 0;
    while (bc < 20) begin
      len = $urandom_range(1, 3);
      step = ~step;
      repeat (len) begin
        tick();
        if (clk_en) ne++;
      end
      bc += len;
    end
    step = 1'b0;
    repeat (12) begin
      tick();
      if (clk_en) ne++;
    end
    check("bounce_n", ne, pop());
    check("bounce_count", count, pop());

    steps = 4'd1;
    exp_q.push_back(1); exp_q.push_back(8);
    press_window(1, 0, 16, -1, first, last, n, hnext);
    check("after_bounce_n", n, pop());
    check("after_bounce_count", count, pop());

    exp_q.push_back(56); exp_q.push_back(64);
    exp_q.push_back(1); exp_q.push_back(0);
    base = en_seen;
    run = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 9) run = 1'b0;
      if (en_seen - base >= 50) break;
    end
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 9) run = 1'b0;
    end
    check("run_enabled", en_seen - base, pop());
    check("run_count", count, pop());
    check("run_count_sb", count, en_seen);
    check("run_halted", halted, pop());
    check("run_clk_en", clk_en, pop());

    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(0);
    press_window(0, 1, 20, -1, first, last, n, hnext);
    rst_n = 1'b0;
    tick();
    check("midrun_rst_halted", halted, pop());
    check("midrun_rst_clk_en", clk_en, pop());
    check("midrun_rst_count", count, pop());
    rst_n = 1'b1;
    en_seen = 0;
    repeat (4) tick();
    check("post_rst_halted", halted, pop());
    check("post_rst_clk_en", clk_en, pop());

    bp_en = 1'b1;
    bp_addr = 10'h005;
    exp_q.push_back(5); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(5); exp_q.push_back(0);
    press_window(0, 1, 30, -1, first, last, n, hnext);
    check("bp_pc", pc, pop());
    check("bp_hit", bp_hit, pop());
    check("bp_halted", halted, pop());
    check("bp_count", count, pop());
    check("bp_clk_en", clk_en, pop());

    exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(18); exp_q.push_back(18);
    press_window(0, 1, 20, -1, first, last, n, hnext);
    check("resume_bp_hit", bp_hit, pop());
    check("resume_halted", halted, pop());
    check("resume_pc", pc, pop());
    check("resume_count", count, pop());

    exp_q.push_back(1);
    press_window(0, 1, 20, -1, first, last, n, hnext);
    check("resume_stop_halted", halted, pop());

    bp_en = 1'b0;
    steps = 4'd2;
    exp_q.push_back(24); exp_q.push_back(0);
    press_window(1, 1, 30, -1, first, last, n, hnext);
    check("both_press_n", n, pop());
    check("both_press_halted", halted, pop());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
